// File: rtl/mealy_seq_detector_pkg.sv
// Shared constants and types for the Mealy sequence detector.
// Default pattern width, reset pattern and counter width, the operation
// decode used by the state process, and the fill-counter width helper.
package mealy_seq_detector_pkg;

  localparam int         DEF_PATTERN_W   = 3;
  localparam logic [2:0] DEF_PATTERN_RST = 3'b111;
  localparam int         DEF_CNT_W       = 8;

  // What the state process does with history/fill/pattern this cycle
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,  // no accepted bit, no load: everything holds
    OP_SHIFT = 2'd1,  // accepted bit shifts into the history
    OP_CLEAR = 2'd2,  // match in non-overlap mode: history restarts
    OP_LOAD  = 2'd3   // new pattern written, history restarts
  } op_e;

  // Bits needed to hold fill values 0..pattern_w-1 (pattern_w >= 2)
  function automatic int fill_width(input int pattern_w);
    if (pattern_w <= 2) begin
      return 1;
    end else begin
      return $clog2(pattern_w);
    end
  endfunction

endpackage

// File: rtl/mealy_seq_detector_if.sv
// Serial-bit / pattern-load / status bundle of the sequence detector.
// The master drives the bit stream and pattern loads; the slave (the
// detector) returns the match pulse, armed flag and match count.
interface mealy_seq_detector_if
  import mealy_seq_detector_pkg::*;
#(
  parameter int PATTERN_W = DEF_PATTERN_W,
  parameter int CNT_W     = DEF_CNT_W
);

  logic                 en;
  logic                 w;
  logic                 load;
  logic [PATTERN_W-1:0] pattern_in;
  logic                 z;
  logic                 armed;
  logic [CNT_W-1:0]     match_cnt;

  modport master (
    output en, w, load, pattern_in,
    input  z, armed, match_cnt
  );

  modport slave (
    input  en, w, load, pattern_in,
    output z, armed, match_cnt
  );

endinterface

// File: rtl/mealy_seq_detector_match_out_logic.sv
// Mealy output logic of the sequence detector.
// z is raised in the same cycle as the final accepted bit when the history
// is full and history plus the incoming bit equals the stored pattern.
// A load in the same cycle suppresses the match.
module match_out_logic #(
  parameter int PATTERN_W = 3
) (
  input  logic                 i_w,
  input  logic                 i_en,
  input  logic                 i_load,
  input  logic                 i_armed,
  input  logic [PATTERN_W-2:0] i_hist,
  input  logic [PATTERN_W-1:0] i_pat,
  output logic                 o_z
);

  logic [PATTERN_W-1:0] w_window;

  assign w_window = {i_hist, i_w};

  // Combinational match decision from state and current inputs
  always_comb begin
    o_z = 1'b0;
    if (i_en && !i_load && i_armed && (w_window == i_pat)) begin
      o_z = 1'b1;
    end else begin
      o_z = 1'b0;
    end
  end

endmodule

// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy sequence detector.
// Watches the serial bit stream and pulses z in the same cycle the last
// PATTERN_W accepted bits equal the programmable pattern (MSB oldest).
// The fill counter doubles as the FSM state: FILL_0 .. ARMED.
module mealy_seq_detector
  import mealy_seq_detector_pkg::*;
#(
  parameter int                   PATTERN_W   = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN_RST = PATTERN_W'(DEF_PATTERN_RST),
  parameter bit                   OVERLAP     = 1'b1,
  parameter int                   CNT_W       = DEF_CNT_W
) (
  input logic                 i_clk,
  input logic                 i_reset,
  mealy_seq_detector_if.slave bus
);

  localparam int                FILL_W  = fill_width(PATTERN_W);
  localparam logic [FILL_W-1:0] FILL_0  = {FILL_W{1'b0}};
  localparam logic [FILL_W-1:0] ARMED   = FILL_W'(PATTERN_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  logic [PATTERN_W-2:0] r_hist;
  logic [FILL_W-1:0]    r_fill;
  logic [PATTERN_W-1:0] r_pat;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_armed;

  logic                 w_z_raw;
  logic                 w_z;
  logic [PATTERN_W-2:0] w_hist_next;
  logic [FILL_W-1:0]    w_fill_next;
  op_e                  w_op;

  match_out_logic #(
    .PATTERN_W (PATTERN_W)
  ) u_match_out_logic (
    .i_w     (bus.w),
    .i_en    (bus.en),
    .i_load  (bus.load),
    .i_armed (r_armed),
    .i_hist  (r_hist),
    .i_pat   (r_pat),
    .o_z     (w_z_raw)
  );

  // A match is never reported while reset is held
  assign w_z = w_z_raw & ~i_reset;

  // History shift: newest bit enters at the LSB, oldest falls off the top
  if (PATTERN_W > 2) begin : g_hist_wide
    assign w_hist_next = {r_hist[PATTERN_W-3:0], bus.w};
  end else begin : g_hist_one
    assign w_hist_next = bus.w;
  end

  // Saturating fill increment: ARMED is the steady state
  always_comb begin
    w_fill_next = r_fill;
    if (r_fill == ARMED) begin
      w_fill_next = ARMED;
    end else begin
      w_fill_next = r_fill + FILL_W'(1);
    end
  end

  // Decode this cycle's operation; load wins over an accepted bit
  always_comb begin
    w_op = OP_HOLD;
    if (bus.load) begin
      w_op = OP_LOAD;
    end else if (bus.en) begin
      if (w_z && !OVERLAP) begin
        w_op = OP_CLEAR;
      end else begin
        w_op = OP_SHIFT;
      end
    end else begin
      w_op = OP_HOLD;
    end
  end

  // Detector state: history, fill/armed, pattern and saturating match count
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hist  <= {(PATTERN_W-1){1'b0}};
      r_fill  <= FILL_0;
      r_armed <= 1'b0;
      r_pat   <= PATTERN_RST;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      case (w_op)
        OP_LOAD: begin
          r_pat   <= bus.pattern_in;
          r_hist  <= {(PATTERN_W-1){1'b0}};
          r_fill  <= FILL_0;
          r_armed <= 1'b0;
        end
        OP_CLEAR: begin
          r_hist  <= {(PATTERN_W-1){1'b0}};
          r_fill  <= FILL_0;
          r_armed <= 1'b0;
        end
        OP_SHIFT: begin
          r_hist  <= w_hist_next;
          r_fill  <= w_fill_next;
          r_armed <= (w_fill_next == ARMED);
        end
        OP_HOLD: begin
          r_hist  <= r_hist;
          r_fill  <= r_fill;
          r_armed <= r_armed;
        end
        default: begin
          r_hist  <= r_hist;
          r_fill  <= r_fill;
          r_armed <= r_armed;
        end
      endcase
      if (w_z && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign bus.z         = w_z;
  assign bus.armed     = r_armed;
  assign bus.match_cnt = r_cnt;

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Directed bench for mealy_seq_detector.
// Three instances share one stimulus stream: overlap mode, non-overlap mode,
// and overlap mode with a 2-bit match counter for the saturation check.
module tb_mealy_seq_detector;

  typedef struct {
    logic       rst;
    logic       en;
    logic       w;
    logic       load;
    logic [2:0] pat_in;
    logic       ov_z;
    logic       ov_armed;
    logic [7:0] ov_cnt;
    logic       no_z;
    logic       no_armed;
    logic [7:0] no_cnt;
  } vec_t;

  vec_t vq[$];

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mealy_seq_detector_if #(.PATTERN_W(3), .CNT_W(8)) if_ov ();
  mealy_seq_detector_if #(.PATTERN_W(3), .CNT_W(8)) if_no ();
  mealy_seq_detector_if #(.PATTERN_W(3), .CNT_W(2)) if_c2 ();

  mealy_seq_detector #(.PATTERN_W(3), .PATTERN_RST(3'b111), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .i_clk (clk), .i_reset (rst), .bus (if_ov)
  );
  mealy_seq_detector #(.PATTERN_W(3), .PATTERN_RST(3'b111), .OVERLAP(1'b0), .CNT_W(8)) u_no (
    .i_clk (clk), .i_reset (rst), .bus (if_no)
  );
  mealy_seq_detector #(.PATTERN_W(3), .PATTERN_RST(3'b111), .OVERLAP(1'b1), .CNT_W(2)) u_c2 (
    .i_clk (clk), .i_reset (rst), .bus (if_c2)
  );

  task automatic add(input logic r, input logic e, input logic b, input logic l,
                     input logic [2:0] p,
                     input logic oz, input logic oa, input logic [7:0] oc,
                     input logic nz, input logic na, input logic [7:0] nc);
    vec_t v;
    v.rst = r; v.en = e; v.w = b; v.load = l; v.pat_in = p;
    v.ov_z = oz; v.ov_armed = oa; v.ov_cnt = oc;
    v.no_z = nz; v.no_armed = na; v.no_cnt = nc;
    vq.push_back(v);
  endtask

  task automatic drive(input logic r, input logic e, input logic b, input logic l,
                       input logic [2:0] p);
    rst = r;
    if_ov.en = e; if_ov.w = b; if_ov.load = l; if_ov.pattern_in = p;
    if_no.en = e; if_no.w = b; if_no.load = l; if_no.pattern_in = p;
    if_c2.en = e; if_c2.w = b; if_c2.load = l; if_c2.pattern_in = p;
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] got,
                       input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, got, exp);
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    repeat (2) @(posedge clk);

    //   rst en w ld pat     ov: z a cnt        no: z a cnt
    // reset state
    add(1, 0, 0, 0, 3'b000,  0, 0, 8'd0,  0, 0, 8'd0);
    // stream 1,1,1,1,0,1,1,1 against 111
    add(0, 1, 1, 0, 3'b000,  0, 0, 8'd0,  0, 0, 8'd0);
    add(0, 1, 1, 0, 3'b000,  0, 0, 8'd0,  0, 0, 8'd0);
    add(0, 1, 1, 0, 3'b000,  1, 1, 8'd0,  1, 1, 8'd0);
    add(0, 1, 1, 0, 3'b000,  1, 1, 8'd1,  0, 0, 8'd1);
    add(0, 1, 0, 0, 3'b000,  0, 1, 8'd2,  0, 0, 8'd1);
    add(0, 1, 1, 0, 3'b000,  0, 1, 8'd2,  0, 1, 8'd1);
    add(0, 1, 1, 0, 3'b000,  0, 1, 8'd2,  0, 1, 8'd1);
    add(0, 1, 1, 0, 3'b000,  1, 1, 8'd2,  1, 1, 8'd1);
    add(0, 0, 0, 0, 3'b000,  0, 1, 8'd3,  0, 0, 8'd2);
    // load 101, then 1,0,1,0,1
    add(0, 0, 0, 1, 3'b101,  0, 1, 8'd3,  0, 0, 8'd2);
    add(0, 1, 1, 0, 3'b000,  0, 0, 8'd3,  0, 0, 8'd2);
    add(0, 1, 0, 0, 3'b000,  0, 0, 8'd3,  0, 0, 8'd2);
    add(0, 1, 1, 0, 3'b000,  1, 1, 8'd3,  1, 1, 8'd2);
    add(0, 1, 0, 0, 3'b000,  0, 1, 8'd4,  0, 0, 8'd3);
    add(0, 1, 1, 0, 3'b000,  1, 1, 8'd4,  0, 0, 8'd3);
    // load 111, then 1,1,(en=0 x3),1
    add(0, 0, 0, 1, 3'b111,  0, 1, 8'd5,  0, 1, 8'd3);
    add(0, 1, 1, 0, 3'b000,  0, 0, 8'd5,  0, 0, 8'd3);
    add(0, 1, 1, 0, 3'b000,  0, 0, 8'd5,  0, 0, 8'd3);
    add(0, 0, 1, 0, 3'b000,  0, 1, 8'd5,  0, 1, 8'd3);
    add(0, 0, 1, 0, 3'b000,  0, 1, 8'd5,  0, 1, 8'd3);
    add(0, 0, 1, 0, 3'b000,  0, 1, 8'd5,  0, 1, 8'd3);
    add(0, 1, 1, 0, 3'b000,  1, 1, 8'd5,  1, 1, 8'd3);
    add(0, 0, 0, 0, 3'b000,  0, 1, 8'd6,  0, 0, 8'd4);
    // load 110 with en=1,w=1 while armed on hist 11: bit discarded
    add(0, 1, 1, 1, 3'b110,  0, 1, 8'd6,  0, 0, 8'd4);
    add(0, 0, 0, 0, 3'b000,  0, 0, 8'd6,  0, 0, 8'd4);
    add(0, 1, 1, 0, 3'b000,  0, 0, 8'd6,  0, 0, 8'd4);
    add(0, 1, 1, 0, 3'b000,  0, 0, 8'd6,  0, 0, 8'd4);
    add(0, 1, 0, 0, 3'b000,  1, 1, 8'd6,  1, 1, 8'd4);
    // load 111, 1,1, reset with w=1, then 1,1,1
    add(0, 0, 0, 1, 3'b111,  0, 1, 8'd7,  0, 0, 8'd5);
    add(0, 1, 1, 0, 3'b000,  0, 0, 8'd7,  0, 0, 8'd5);
    add(0, 1, 1, 0, 3'b000,  0, 0, 8'd7,  0, 0, 8'd5);
    add(1, 1, 1, 0, 3'b000,  0, 1, 8'd7,  0, 1, 8'd5);
    add(0, 1, 1, 0, 3'b000,  0, 0, 8'd0,  0, 0, 8'd0);
    add(0, 1, 1, 0, 3'b000,  0, 0, 8'd0,  0, 0, 8'd0);
    add(0, 1, 1, 0, 3'b000,  1, 1, 8'd0,  1, 1, 8'd0);
    add(0, 0, 0, 0, 3'b000,  0, 1, 8'd1,  0, 0, 8'd1);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].rst, vq[i].en, vq[i].w, vq[i].load, vq[i].pat_in);
      #1;
      check("ov_z",     i, {7'd0, if_ov.z},     {7'd0, vq[i].ov_z});
      check("ov_armed", i, {7'd0, if_ov.armed}, {7'd0, vq[i].ov_armed});
      check("ov_cnt",   i, if_ov.match_cnt,     vq[i].ov_cnt);
      check("no_z",     i, {7'd0, if_no.z},     {7'd0, vq[i].no_z});
      check("no_armed", i, {7'd0, if_no.armed}, {7'd0, vq[i].no_armed});
      check("no_cnt",   i, if_no.match_cnt,     vq[i].no_cnt);
    end

    // Counter saturation: after reset, seven 1s give five matches
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    for (int k = 1; k <= 7; k++) begin
      int exp_ov;
      int exp_c2;
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
      #1;
      exp_ov = (k <= 3) ? 0 : k - 3;
      exp_c2 = (exp_ov > 3) ? 3 : exp_ov;
      check("sat_c2_z",   k, {7'd0, if_c2.z},         (k >= 3) ? 8'd1 : 8'd0);
      check("sat_c2_cnt", k, {6'd0, if_c2.match_cnt}, 8'(exp_c2));
      check("sat_ov_cnt", k, if_ov.match_cnt,         8'(exp_ov));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    #1;
    check("sat_c2_final", 8, {6'd0, if_c2.match_cnt}, 8'd3);
    check("sat_ov_final", 8, if_ov.match_cnt,         8'd5);
    check("sat_c2_idle_z", 8, {7'd0, if_c2.z},        8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
